// File: rtl/calc_design_pkg.sv
// -----------------------------------------------------------------------------
// calc_design_pkg
// Shared definitions for the calculator datapath:
//   - CALC_WIDTH    : default data path width in bits
//   - calc_code_t   : 6-bit control code {zx, nx, zy, ny, f, no}
//   - CODE_*        : the 18 standard control codes
//   - code_is_standard() : true when a code is one of the 18 named codes
// No ports (package).
// -----------------------------------------------------------------------------
package calc_design_pkg;

    localparam int CALC_WIDTH = 8;

    // Bit order, MSB first: zx nx zy ny f no
    typedef logic [5:0] calc_code_t;

    // Constants
    localparam calc_code_t CODE_ZERO      = 6'b101010;
    localparam calc_code_t CODE_ONE       = 6'b111111;
    localparam calc_code_t CODE_MINUS_ONE = 6'b111010;
    // Pass and invert
    localparam calc_code_t CODE_X         = 6'b001100;
    localparam calc_code_t CODE_Y         = 6'b110000;
    localparam calc_code_t CODE_NOT_X     = 6'b001101;
    localparam calc_code_t CODE_NOT_Y     = 6'b110001;
    // Negate
    localparam calc_code_t CODE_NEG_X     = 6'b001111;
    localparam calc_code_t CODE_NEG_Y     = 6'b110011;
    // Increment / decrement
    localparam calc_code_t CODE_X_INC     = 6'b011111;
    localparam calc_code_t CODE_Y_INC     = 6'b110111;
    localparam calc_code_t CODE_X_DEC     = 6'b001110;
    localparam calc_code_t CODE_Y_DEC     = 6'b110010;
    // Arithmetic
    localparam calc_code_t CODE_X_PLUS_Y  = 6'b000010;
    localparam calc_code_t CODE_X_MINUS_Y = 6'b010011;
    localparam calc_code_t CODE_Y_MINUS_X = 6'b000111;
    // Logic
    localparam calc_code_t CODE_X_AND_Y   = 6'b000000;
    localparam calc_code_t CODE_X_OR_Y    = 6'b010101;

    // Every 6-bit code is legal; this only tells whether a code has a name.
    function automatic logic code_is_standard(input calc_code_t code);
        logic hit;
        hit = 1'b0;
        case (code)
            CODE_ZERO, CODE_ONE, CODE_MINUS_ONE,
            CODE_X, CODE_Y, CODE_NOT_X, CODE_NOT_Y,
            CODE_NEG_X, CODE_NEG_Y,
            CODE_X_INC, CODE_Y_INC, CODE_X_DEC, CODE_Y_DEC,
            CODE_X_PLUS_Y, CODE_X_MINUS_Y, CODE_Y_MINUS_X,
            CODE_X_AND_Y, CODE_X_OR_Y: hit = 1'b1;
            default:                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/calc_alu_core.sv
// -----------------------------------------------------------------------------
// calc_alu_core
// Purely combinational calculator datapath: operand preprocessing
// (zero / invert), AND-or-ADD function, optional result inversion and the
// zero / negative flags derived from the result.
// Ports:
//   x_i, y_i     : operands (WIDTH bits)
//   zx_i, nx_i   : zero X, then invert X
//   zy_i, ny_i   : zero Y, then invert Y
//   f_i          : 1 = add (carry-out dropped), 0 = bitwise AND
//   no_i         : invert the function result
//   r_o          : result
//   zr_o         : result is all zeros
//   ng_o         : result MSB (negative in two's complement)
// -----------------------------------------------------------------------------
module calc_alu_core
    import calc_design_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             zx_i,
    input  logic             nx_i,
    input  logic             zy_i,
    input  logic             ny_i,
    input  logic             f_i,
    input  logic             no_i,
    output logic [WIDTH-1:0] r_o,
    output logic             zr_o,
    output logic             ng_o
);

    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] fr;

    // Per-bit preprocessing: zeroing happens first, inversion second, so
    // zx=1,nx=1 yields all ones.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic xa_bit;
            logic ya_bit;
            assign xa_bit      = x_i[gi] & ~zx_i;
            assign ya_bit      = y_i[gi] & ~zy_i;
            assign xb[gi]      = xa_bit ^ nx_i;
            assign yb[gi]      = ya_bit ^ ny_i;
            assign and_res[gi] = xb[gi] & yb[gi];
        end
    endgenerate

    // Sum truncated to WIDTH bits: wraps modulo 2^WIDTH, no overflow flag.
    assign add_res = xb + yb;

    assign fr   = f_i ? add_res : and_res;
    assign r_o  = no_i ? ~fr : fr;
    assign zr_o = (r_o == '0);
    assign ng_o = r_o[WIDTH-1];

endmodule

// File: rtl/calc_design.sv
// -----------------------------------------------------------------------------
// calc_design
// One-cycle-latency calculator. The combinational datapath lives in
// calc_alu_core; this level only registers the result and flags and tracks
// validity. A result is captured on every edge where in_valid is high; with
// in_valid low the result and flags hold and out_valid drops.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   x, y                : operands (WIDTH bits)
//   zx, nx, zy, ny, f, no : control code bits
//   in_valid            : operands/controls valid this cycle
//   o, zr, ng           : registered result, zero flag, negative flag
//   out_valid           : o/zr/ng were updated on the last edge
// -----------------------------------------------------------------------------
module calc_design
    import calc_design_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             in_valid,
    output logic             zr,
    output logic             ng,
    output logic [WIDTH-1:0] o,
    output logic             out_valid
);

    logic [WIDTH-1:0] r_n;
    logic             zr_n;
    logic             ng_n;

    logic [WIDTH-1:0] o_q,  o_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             out_valid_q, out_valid_d;

    calc_alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .x_i  (x),
        .y_i  (y),
        .zx_i (zx),
        .nx_i (nx),
        .zy_i (zy),
        .ny_i (ny),
        .f_i  (f),
        .no_i (no),
        .r_o  (r_n),
        .zr_o (zr_n),
        .ng_o (ng_n)
    );

    // Capture on a valid input, otherwise hold the last result.
    always_comb begin
        o_d         = o_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            o_d         = r_n;
            zr_d        = zr_n;
            ng_d        = ng_n;
            out_valid_d = 1'b1;
        end
    end

    // Reset wins over a coincident valid input; that operation is dropped.
    // Reset state is a consistent "result = 0": zr set, ng clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_q         <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            o_q         <= o_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o         = o_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_calc_design.sv
module tb_calc_design;
    import calc_design_pkg::*;

    localparam int W = 8;
    localparam int unsigned M = 256;

    logic         clk;
    logic         reset;
    logic [W-1:0] x, y;
    logic         zx, nx, zy, ny, f, no;
    logic         in_valid;
    logic         zr, ng;
    logic [W-1:0] o;
    logic         out_valid;

    int n_checks;
    int n_errors;

    calc_design #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .in_valid(in_valid), .zr(zr), .ng(ng), .o(o), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference from the arithmetic rules: zeroing, complement as (M-1)-v,
    // addition modulo M, AND on integers.
    function automatic int unsigned ref_calc(input logic [5:0] c,
                                             input int unsigned xv,
                                             input int unsigned yv);
        int unsigned a, b, r;
        a = c[5] ? 0 : xv;
        if (c[4]) a = (M - 1) - a;
        b = c[3] ? 0 : yv;
        if (c[2]) b = (M - 1) - b;
        r = c[1] ? (a + b) % M : (a & b);
        if (c[0]) r = (M - 1) - r;
        return r;
    endfunction

    // Meaning of the named codes, independent of the bit-level rules.
    function automatic int unsigned table_calc(input int idx,
                                               input int unsigned xv,
                                               input int unsigned yv);
        case (idx)
            0:  return 0;
            1:  return 1;
            2:  return M - 1;
            3:  return xv;
            4:  return yv;
            5:  return (M - 1) - xv;
            6:  return (M - 1) - yv;
            7:  return (M - xv) % M;
            8:  return (M - yv) % M;
            9:  return (xv + 1) % M;
            10: return (yv + 1) % M;
            11: return (xv + M - 1) % M;
            12: return (yv + M - 1) % M;
            13: return (xv + yv) % M;
            14: return (xv + M - yv) % M;
            15: return (yv + M - xv) % M;
            16: return xv & yv;
            default: return xv | yv;
        endcase
    endfunction

    logic [5:0] std_codes [18];
    initial begin
        std_codes[0]  = CODE_ZERO;      std_codes[1]  = CODE_ONE;
        std_codes[2]  = CODE_MINUS_ONE; std_codes[3]  = CODE_X;
        std_codes[4]  = CODE_Y;         std_codes[5]  = CODE_NOT_X;
        std_codes[6]  = CODE_NOT_Y;     std_codes[7]  = CODE_NEG_X;
        std_codes[8]  = CODE_NEG_Y;     std_codes[9]  = CODE_X_INC;
        std_codes[10] = CODE_Y_INC;     std_codes[11] = CODE_X_DEC;
        std_codes[12] = CODE_Y_DEC;     std_codes[13] = CODE_X_PLUS_Y;
        std_codes[14] = CODE_X_MINUS_Y; std_codes[15] = CODE_Y_MINUS_X;
        std_codes[16] = CODE_X_AND_Y;   std_codes[17] = CODE_X_OR_Y;
    end

    task automatic drive(input logic [5:0] c, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic v);
        {zx, nx, zy, ny, f, no} = c;
        x = xv;
        y = yv;
        in_valid = v;
    endtask

    // One edge, then settle; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(CODE_ONE, 8'h5A, 8'hA5, 1'b1);
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (o !== 8'h00 || zr !== 1'b1 || ng !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: o=%h zr=%b ng=%b ov=%b, want o=00 zr=1 ng=0 ov=0",
                     o, zr, ng, out_valid);
        end
        $display("reset: o=%h zr=%b ng=%b ov=%b", o, zr, ng, out_valid);
        reset = 1'b0;
        drive(6'b0, 8'h00, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_constants();
        logic [5:0] codes [3];
        logic [W-1:0] exp_o [3];
        codes[0] = 6'b101010; codes[1] = 6'b111111; codes[2] = 6'b111010;
        exp_o[0] = 8'h00;     exp_o[1] = 8'h01;     exp_o[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            drive(codes[i], 8'hFF, 8'hCF, 1'b1);
            step();
            n_checks++;
            if (o !== exp_o[i] || zr !== (i == 0) || ng !== (i == 2) || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL const[%0d]: o=%h zr=%b ng=%b ov=%b, want o=%h zr=%b ng=%b ov=1",
                         i, o, zr, ng, out_valid, exp_o[i], (i == 0), (i == 2));
            end
            $display("const code=%b: o=%h zr=%b ng=%b", codes[i], o, zr, ng);
        end
    endtask

    task automatic test_add_sub();
        logic [5:0] codes [3];
        logic [W-1:0] exp_o [3];
        logic exp_ng [3];
        codes[0] = 6'b000010; exp_o[0] = 8'hA0; exp_ng[0] = 1'b1;
        codes[1] = 6'b010011; exp_o[1] = 8'h4C; exp_ng[1] = 1'b0;
        codes[2] = 6'b000111; exp_o[2] = 8'hB4; exp_ng[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(codes[i], 8'h76, 8'h2A, 1'b1);
            step();
            n_checks++;
            if (o !== exp_o[i] || ng !== exp_ng[i] || zr !== 1'b0 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL addsub[%0d]: o=%h zr=%b ng=%b ov=%b, want o=%h zr=0 ng=%b ov=1",
                         i, o, zr, ng, out_valid, exp_o[i], exp_ng[i]);
            end
            $display("addsub code=%b: o=%h zr=%b ng=%b", codes[i], o, zr, ng);
        end
    endtask

    task automatic test_logic();
        drive(6'b000000, 8'hFF, 8'hCF, 1'b1);
        step();
        n_checks++;
        if (o !== 8'hCF || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL and: o=%h ov=%b, want o=cf ov=1", o, out_valid);
        end
        $display("and: o=%h", o);
        drive(6'b010101, 8'h1C, 8'hF5, 1'b1);
        step();
        n_checks++;
        if (o !== 8'hFD || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL or: o=%h ov=%b, want o=fd ov=1", o, out_valid);
        end
        $display("or: o=%h", o);
    endtask

    task automatic test_standard_codes();
        int unsigned xv, yv, e;
        for (int i = 0; i < 18; i++) begin
            xv = $urandom_range(0, M - 1);
            yv = $urandom_range(0, M - 1);
            e  = table_calc(i, xv, yv);
            drive(std_codes[i], xv[W-1:0], yv[W-1:0], 1'b1);
            step();
            n_checks++;
            if (int'(o) != e || zr !== (e == 0) || ng !== (e >= M / 2)) begin
                n_errors++;
                $display("FAIL std code=%b x=%h y=%h: o=%h zr=%b ng=%b, want o=%h",
                         std_codes[i], xv[W-1:0], yv[W-1:0], o, zr, ng, e[W-1:0]);
            end
            $display("std code=%b x=%h y=%h: o=%h", std_codes[i], xv[W-1:0], yv[W-1:0], o);
        end
    endtask

    task automatic test_all_codes();
        int unsigned xv, yv, e;
        logic [5:0] c;
        for (int i = 0; i < 64; i++) begin
            c  = i[5:0];
            xv = $urandom_range(0, M - 1);
            yv = (i % 8 == 0) ? xv : $urandom_range(0, M - 1);
            e  = ref_calc(c, xv, yv);
            drive(c, xv[W-1:0], yv[W-1:0], 1'b1);
            step();
            n_checks++;
            if (int'(o) != e || zr !== (e == 0) || ng !== (e >= M / 2) || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL code=%b x=%h y=%h: o=%h zr=%b ng=%b ov=%b, want o=%h",
                         c, xv[W-1:0], yv[W-1:0], o, zr, ng, out_valid, e[W-1:0]);
            end
            $display("code=%b x=%h y=%h: o=%h zr=%b ng=%b", c, xv[W-1:0], yv[W-1:0], o, zr, ng);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned xv, yv, e, last;
        logic [5:0] c;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            c  = std_codes[$urandom_range(0, 17)];
            xv = $urandom_range(0, M - 1);
            yv = $urandom_range(0, M - 1);
            e  = ref_calc(c, xv, yv);
            drive(c, xv[W-1:0], yv[W-1:0], 1'b1);
            step();
            n_checks++;
            if (int'(o) != e || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stream[%0d]: o=%h ov=%b, want o=%h ov=1", i, o, out_valid, e[W-1:0]);
            end
            $display("stream[%0d] code=%b: o=%h ov=%b", i, c, o, out_valid);
            last = e;
        end
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            step();
            n_checks++;
            if (int'(o) != last || zr !== (last == 0) || ng !== (last >= M / 2) || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL hold[%0d]: o=%h ov=%b, want o=%h ov=0", i, o, out_valid, last[W-1:0]);
            end
            $display("hold[%0d]: o=%h ov=%b", i, o, out_valid);
        end
    endtask

    task automatic test_reset_collision();
        drive(CODE_MINUS_ONE, 8'h00, 8'h00, 1'b1);
        step();
        drive(CODE_ONE, 8'h12, 8'h34, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (o !== 8'h00 || zr !== 1'b1 || ng !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL collision: o=%h zr=%b ng=%b ov=%b, want o=00 zr=1 ng=0 ov=0",
                     o, zr, ng, out_valid);
        end
        $display("collision: o=%h zr=%b ov=%b", o, zr, out_valid);
    endtask

    task automatic test_reset_midstream();
        int unsigned e;
        drive(CODE_X, 8'h9C, 8'h00, 1'b1);
        step();
        drive(CODE_Y, 8'h00, 8'h77, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (o !== 8'h00 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset: o=%h ov=%b, want o=00 ov=0", o, out_valid);
        end
        drive(CODE_X_MINUS_Y, 8'h10, 8'h31, 1'b1);
        e = ref_calc(CODE_X_MINUS_Y, 32'h10, 32'h31);
        step();
        drive(6'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (int'(o) != e || out_valid !== 1'b1 || ng !== 1'b1) begin
            n_errors++;
            $display("FAIL post-reset first: o=%h ov=%b ng=%b, want o=%h ov=1 ng=1",
                     o, out_valid, ng, e[W-1:0]);
        end
        $display("post-reset first: o=%h ov=%b", o, out_valid);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        drive(6'b0, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_constants();
        test_add_sub();
        test_logic();
        test_standard_codes();
        test_all_codes();
        test_back_to_back();
        test_reset_collision();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
